// File: rtl/instr_fetch_if.sv
// Memory bus and instruction hand-off between the fetch unit (master side)
// and the RAM / decode stage (slave side).
interface instr_fetch_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_cs;
    logic                  mem_oe;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] ir1;
    logic [DATA_WIDTH-1:0] ir2;
    logic [ADDR_WIDTH-1:0] ir_pc;
    logic                  ir_valid;
    logic                  ir_ready;

    modport master (
        output mem_addr, mem_cs, mem_oe, mem_we, ir1, ir2, ir_pc, ir_valid,
        input  mem_rdata, ir_ready
    );

    modport slave (
        input  mem_addr, mem_cs, mem_oe, mem_we, ir1, ir2, ir_pc, ir_valid,
        output mem_rdata, ir_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Two-byte instruction fetch unit in front of a single-port synchronous RAM.
// Reads opcode and operand on consecutive cycles and presents them as a pair
// with a valid/ready handshake. Supports redirect (pc_load) and abort (stop).
//
// state | meaning
// IDLE  | waiting for start, no memory access
// F1    | address pc presented to RAM
// F2    | address pc+1 presented, opcode byte captured at end of cycle
// F3    | RAM idle, operand byte captured, pc advanced by 2
// VALID | pair presented, waiting for ir_ready
//
// RAM controls and address are registered from the next state so they are
// glitch-free and mem_addr naturally holds its last value outside F1/F2.
module instr_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_pc,
    input  logic                  stop,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_val,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    instr_fetch_if.master         bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        F1    = 3'd1,
        F2    = 3'd2,
        F3    = 3'd3,
        VALID = 3'd4
    } state_t;

    state_t state, next_state;

    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_en_q;
    logic [DATA_WIDTH-1:0] ir1_q;
    logic [DATA_WIDTH-1:0] ir2_q;
    logic [ADDR_WIDTH-1:0] ir_pc_q;

    logic start_now;
    logic load_now;
    logic accept_now;

    // Event decode with priority stop > pc_load > start/handshake.
    always_comb begin
        start_now  = (state == IDLE) && start && !stop;
        load_now   = (state != IDLE) && pc_load && !stop;
        accept_now = (state == VALID) && bus.ir_ready && !pc_load && !stop;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        if (stop) begin
            next_state = IDLE;
        end else if (load_now) begin
            next_state = F1;
        end else begin
            case (state)
                IDLE:    if (start) next_state = F1;
                F1:      next_state = F2;
                F2:      next_state = F3;
                F3:      next_state = VALID;
                VALID:   if (bus.ir_ready) next_state = F1;
                default: next_state = IDLE;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        bus.ir_valid = (state == VALID);
        busy         = (state != IDLE);
        bus.mem_we   = 1'b0;
    end

    // Datapath: pc, RAM address/enables and instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            mem_addr_q <= '0;
            mem_en_q   <= 1'b0;
            ir1_q      <= '0;
            ir2_q      <= '0;
            ir_pc_q    <= '0;
        end else begin
            mem_en_q <= (next_state == F1) || (next_state == F2);
            if (start_now) begin
                pc         <= start_pc;
                mem_addr_q <= start_pc;
            end else if (load_now) begin
                pc         <= pc_load_val;
                mem_addr_q <= pc_load_val;
            end else if (!stop) begin
                case (state)
                    F1: mem_addr_q <= pc + ADDR_WIDTH'(1);
                    F2: ir1_q <= bus.mem_rdata;
                    F3: begin
                        ir2_q   <= bus.mem_rdata;
                        ir_pc_q <= pc;
                        pc      <= pc + ADDR_WIDTH'(2);
                    end
                    VALID: if (accept_now) mem_addr_q <= pc;
                    default: ;
                endcase
            end
        end
    end

    // Drive the bus from the internal registers.
    always_comb begin
        bus.mem_addr = mem_addr_q;
        bus.mem_cs   = mem_en_q;
        bus.mem_oe   = mem_en_q;
        bus.ir1      = ir1_q;
        bus.ir2      = ir2_q;
        bus.ir_pc    = ir_pc_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: table of single-pair fetches with back-pressure,
// plus hand-written sequences for streaming, redirect, stop and reset.
module tb_instr_fetch;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] start_pc;
    logic       stop;
    logic       pc_load;
    logic [7:0] pc_load_val;
    logic [7:0] pc;
    logic       busy;

    instr_fetch_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    instr_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_pc    (start_pc),
        .stop        (stop),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .pc          (pc),
        .busy        (busy),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM model.
    logic [7:0] ram [256];
    logic [7:0] rdata_q;
    int         reads;
    initial begin
        rdata_q = 8'h00;
        reads   = 0;
    end
    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_oe) begin
            rdata_q <= ram[bus.mem_addr];
            reads   <= reads + 1;
        end
    end
    assign bus.mem_rdata = rdata_q;

    int total;
    int bad;

    typedef struct {
        logic [7:0] ir1;
        logic [7:0] ir2;
        logic [7:0] ir_pc;
    } pair_t;
    pair_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted transfer is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.ir_valid && bus.ir_ready && !pc_load && !stop) begin
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", {8'h0, bus.ir1, bus.ir2, bus.ir_pc}, 32'hFFFF_FFFF);
            end else begin
                pair_t e;
                e = exp_q.pop_front();
                check("transfer_pair", {8'h0, bus.ir1, bus.ir2, bus.ir_pc},
                      {8'h0, e.ir1, e.ir2, e.ir_pc});
            end
        end
    end

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] p);
        pair_t e;
        e.ir1   = a;
        e.ir2   = b;
        e.ir_pc = p;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start; returns just after the edge that sampled it.
    task automatic do_start(input logic [7:0] a);
        tick();
        start    = 1'b1;
        start_pc = a;
        tick();
        start    = 1'b0;
    endtask

    // Count edges until ir_valid is seen; an expired budget counts as a failure.
    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!bus.ir_valid && n < 12) begin
            tick();
            n++;
        end
        if (!bus.ir_valid) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    typedef struct {
        logic [7:0] spc;
        int         stall;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] epc;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int n;
        int rd_snap;

        vecs[0] = '{8'h00, 0, 8'h10, 8'h0C, 8'h02};
        vecs[1] = '{8'h02, 5, 8'h20, 8'h0E, 8'h04};
        vecs[2] = '{8'hFF, 0, 8'h70, 8'h10, 8'h01};
        vecs[3] = '{8'hFE, 1, 8'h5B, 8'h70, 8'h00};
        vecs[4] = '{8'h12, 2, 8'h90, 8'h02, 8'h14};
        vecs[5] = '{8'h41, 0, 8'hE4, 8'hE7, 8'h43};
        vecs[6] = '{8'h80, 3, 8'h25, 8'h24, 8'h82};

        for (int i = 0; i < 256; i++) ram[i] = i[7:0] ^ 8'hA5;
        ram[8'h00] = 8'h10;
        ram[8'h01] = 8'h0C;
        ram[8'h02] = 8'h20;
        ram[8'h03] = 8'h0E;
        ram[8'h12] = 8'h90;
        ram[8'h13] = 8'h02;
        ram[8'hFF] = 8'h70;

        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        start_pc     = 8'h00;
        stop         = 1'b0;
        pc_load      = 1'b0;
        pc_load_val  = 8'h00;
        bus.ir_ready = 1'b0;

        #1;
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_ir_valid", bus.ir_valid, 0);
        check("rst_mem", {bus.mem_addr, bus.mem_cs, bus.mem_oe, bus.mem_we}, 0);
        check("rst_ir", {bus.ir1, bus.ir2, bus.ir_pc}, 0);
        #22 rst_n = 1'b1;
        tick();
        check("idle_after_reset", busy, 0);

        // Table: one pair per entry, with back-pressure cycles in VALID.
        for (int v = 0; v < 7; v++) begin
            bus.ir_ready = (vecs[v].stall == 0);
            push_exp(vecs[v].e1, vecs[v].e2, vecs[v].spc);
            do_start(vecs[v].spc);
            check("f1_addr", bus.mem_addr, vecs[v].spc);
            check("f1_cs", bus.mem_cs && bus.mem_oe, 1);
            wait_valid("tbl_valid", n);
            check("tbl_latency", n, 3);
            check("tbl_pc", pc, vecs[v].epc);
            for (int s = 0; s < vecs[v].stall; s++) begin
                check("stall_hold", {bus.ir_valid, bus.ir1, bus.ir2, bus.ir_pc},
                      {1'b1, vecs[v].e1, vecs[v].e2, vecs[v].spc});
                check("stall_cs", bus.mem_cs, 0);
                tick();
            end
            bus.ir_ready = 1'b1;
            tick();
            check("refetch_addr", bus.mem_addr, vecs[v].epc);
            check("refetch_cs", bus.mem_cs, 1);
            do_stop();
            check("stop_idle", busy, 0);
        end

        // Streaming with ir_ready held high: one pair every 4 cycles.
        bus.ir_ready = 1'b1;
        push_exp(8'h10, 8'h0C, 8'h00);
        push_exp(8'h20, 8'h0E, 8'h02);
        do_start(8'h00);
        wait_valid("stream_first", n);
        check("stream_first_lat", n, 3);
        tick();
        wait_valid("stream_second", n);
        check("stream_interval", n + 1, 4);
        tick();
        do_stop();

        // Redirect during F2.
        push_exp(8'h90, 8'h02, 8'h12);
        do_start(8'h00);
        tick();
        pc_load     = 1'b1;
        pc_load_val = 8'h12;
        tick();
        pc_load = 1'b0;
        check("redir_valid_low", bus.ir_valid, 0);
        check("redir_pc", pc, 8'h12);
        check("redir_addr", bus.mem_addr, 8'h12);
        wait_valid("redir_valid", n);
        check("redir_lat", n, 3);
        tick();
        do_stop();

        // pc_load together with a handshake: pair dropped.
        push_exp(8'hE4, 8'hE7, 8'h41);
        do_start(8'h00);
        wait_valid("drop_valid", n);
        pc_load     = 1'b1;
        pc_load_val = 8'h41;
        tick();
        pc_load = 1'b0;
        check("drop_pc", pc, 8'h41);
        check("drop_valid_low", bus.ir_valid, 0);
        wait_valid("drop_next", n);
        check("drop_next_lat", n, 3);
        tick();
        do_stop();

        // stop together with pc_load: back to IDLE, pc unchanged.
        do_start(8'h02);
        tick();
        stop        = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 8'h80;
        tick();
        stop    = 1'b0;
        pc_load = 1'b0;
        check("stopload_busy", busy, 0);
        check("stopload_pc", pc, 8'h02);
        check("stopload_cs_valid", {bus.mem_cs, bus.ir_valid}, 0);
        check("stopload_addr_hold", bus.mem_addr, 8'h03);

        // pc_load in IDLE is ignored.
        pc_load     = 1'b1;
        pc_load_val = 8'h55;
        tick();
        pc_load = 1'b0;
        check("idle_load_pc", pc, 8'h02);
        check("idle_load_busy", busy, 0);

        // Asynchronous reset in the middle of F3.
        bus.ir_ready = 1'b0;
        do_start(8'h41);
        tick();
        tick();
        check("f3_ir1", bus.ir1, 8'hE4);
        rd_snap = reads;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pc", pc, 0);
        check("midrst_cs_valid_busy", {bus.mem_cs, bus.ir_valid, busy}, 0);
        check("midrst_ir1_addr", {bus.ir1, bus.mem_addr}, 0);
        tick();
        check("midrst_ir2", bus.ir2, 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("midrst_idle", busy, 0);
        check("midrst_no_read", reads, rd_snap);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 8, memory address width; DATA_WIDTH, default 8, memory/instruction byte width.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin fetching at start_pc; honoured only in IDLE.
REQ-006 start_pc  input  ADDR_WIDTH  first instruction address.
REQ-007 stop  input  1  abort and return to IDLE.
REQ-008 pc_load  input  1  redirect request from execute (jump/skip/halt).
REQ-009 pc_load_val  input  ADDR_WIDTH  redirect target address.
REQ-010 mem_addr  output  ADDR_WIDTH  address to single-port sync RAM.
REQ-011 mem_cs, mem_oe, mem_we  output  1 each  RAM controls; mem_we tied 0.
REQ-012 mem_rdata  input  DATA_WIDTH  RAM read data, valid one cycle after the address is registered.
REQ-013 ir1, ir2  output  DATA_WIDTH each  opcode byte and operand byte.
REQ-014 ir_pc  output  ADDR_WIDTH  address of ir1.
REQ-015 ir_valid  output  1  instruction pair valid; ir_ready  input  1  decode/execute accepts.
REQ-016 pc  output  ADDR_WIDTH  next fetch address; busy  output  1  high when state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, F1, F2, F3, VALID.
- IDLE -> F1 on start; pc <= start_pc.
- F1: mem_addr = pc, cs = oe = 1. Next state is F2.
- F2: mem_addr = pc+1, cs = oe = 1, ir1 <= mem_rdata at the end of the cycle. Next state is F3.
- F3: cs = 0, ir2 <= mem_rdata at the end of the cycle, ir_pc <= pc, pc <= pc+2. Next state is VALID.
- VALID: ir_valid = 1, cs = 0. Next state is F1 when ir_ready = 1; otherwise stay in VALID.
REQ-018 SHALL assert ir_valid only in VALID, so the first ir_valid comes 3 edges after start is sampled.
REQ-019 SHALL accept a transfer only when ir_valid and ir_ready are both 1 on the same edge.
- ir1, ir2 and ir_pc SHALL hold stable while ir_valid = 1 and ir_ready = 0.
REQ-020 SHALL give a throughput of one instruction per 4 cycles when ir_ready is held high.
REQ-021 SHALL, when pc_load = 1 in any state except IDLE: set pc <= pc_load_val, discard any partial or valid pair (ir_valid low next cycle), and go to F1.
REQ-022 pc_load SHALL take priority over a simultaneous ir_valid/ir_ready handshake; the pair is treated as not transferred.
REQ-023 stop SHALL take priority over pc_load and start: go to IDLE next edge, ir_valid = 0, pc unchanged.
REQ-024 pc_load in IDLE SHALL be ignored.
REQ-025 All address arithmetic SHALL be modulo 2^ADDR_WIDTH.
- pc = FF fetches FF then 00, next pc = 01.
- pc = FE gives next pc = 00.
REQ-026 Odd start_pc and pc_load_val values SHALL be legal; no alignment check.
REQ-027 mem_cs and mem_oe SHALL be 1 only in F1 and F2; mem_addr SHALL hold its last value elsewhere.

Reset
REQ-028 SHALL, on rst_n = 0 and asynchronously, force state = IDLE and all outputs to 0: pc, ir1, ir2, ir_pc, ir_valid, busy, mem_addr, mem_cs, mem_oe.
REQ-029 SHALL abort a fetch in progress on reset with no further memory read.
REQ-030 SHALL leave IDLE only on the first edge after rst_n = 1 that samples start = 1.

Verification
REQ-031 Reset: rst_n = 0 mid-F3 -> ir_valid, mem_cs and pc go to 0 immediately; state IDLE; no ir2 update.
REQ-032 Basic fetch: RAM[00] = 10, RAM[01] = 0C, RAM[02] = 20, RAM[03] = 0E, start_pc = 00, ir_ready = 1 -> ir_valid on edge 3 with ir1 = 10, ir2 = 0C, ir_pc = 00; next pair 20/0E with ir_pc = 02 valid 4 cycles later.
REQ-033 Backpressure: ir_ready = 0 for 5 cycles in VALID -> ir1/ir2/ir_pc stable, mem_cs = 0 throughout; after ir_ready = 1, F1 starts with mem_addr = pc.
REQ-034 Redirect: RAM[12] = 90, RAM[13] = 02, pc_load = 1 with pc_load_val = 12 during F2 -> ir_valid stays 0; the next pair is ir1 = 90, ir2 = 02, ir_pc = 12.
REQ-035 Wrap: start_pc = FF, RAM[FF] = 70, RAM[00] = 10 -> mem_addr FF then 00; ir1 = 70, ir2 = 10; pc = 01.
REQ-036 Simultaneous events: pc_load with ir_valid & ir_ready -> the pair is dropped and pc = pc_load_val; stop together with pc_load -> IDLE and pc unchanged.
